pipe_hazard_ctrl: RTL and testbench

//  Central hazard/sequencing controller of the 5-stage pipeline; supersedes the combinational PC-source logic.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 27 ++
 rtl/pipe_hazard_ctrl_if.sv | 42 ++++
 rtl/pipe_hazard_ctrl_hazard_detect.sv | 32 +++
 rtl/pipe_hazard_ctrl.sv | 143 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/sequencing controller.
// Holds the opcode constants, the next-PC source codes and the FSM state encoding.
package pipe_hazard_ctrl_pkg;

   // Opcodes as seen in the ID and EX stages
   localparam logic [5:0] OpRtype = 6'b000000;
   localparam logic [5:0] OpBeq   = 6'b000100;
   localparam logic [5:0] OpBne   = 6'b000101;
   localparam logic [5:0] OpJ     = 6'b000010;
   localparam logic [5:0] OpLw    = 6'b100011;
   localparam logic [5:0] OpSw    = 6'b101011;

   // Next-PC source select
   typedef enum logic [1:0] {
      PcsSeq = 2'b00,
      PcsBr  = 2'b10,
      PcsJmp = 2'b11
   } pcsrc_e;

   // Controller state
   typedef enum logic [1:0] {
      StRun   = 2'b00,
      StMwait = 2'b01,
      StErr   = 2'b10
   } state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of stage information in, and pipeline control out, for pipe_hazard_ctrl.
//  d_op/d_rs/d_rt  : ID-stage opcode and source registers
//  e_op/e_rt/e_z   : EX-stage opcode, rt (lw destination) and ALU zero flag
//  m_mem_acc/m_rdy : M-stage memory access in flight / data memory ready
//  pcsrc, condep   : next-PC source, ID instruction not cancelled
//  *_wr, *_flush   : per-stage write enables and bubble/flush requests
//  err, stall_cnt  : sticky timeout flag, saturating stall counter
// The master modport is the pipeline side; the slave modport is the controller.
interface pipe_hazard_ctrl_if #(
   parameter int unsigned CNT_W = 16
);
   logic [5:0]       d_op;
   logic [4:0]       d_rs;
   logic [4:0]       d_rt;
   logic [5:0]       e_op;
   logic [4:0]       e_rt;
   logic             e_z;
   logic             m_mem_acc;
   logic             m_rdy;
   logic [1:0]       pcsrc;
   logic             condep;
   logic             pc_wr;
   logic             ifid_wr;
   logic             idex_wr;
   logic             exmem_wr;
   logic             ifid_flush;
   logic             idex_flush;
   logic             err;
   logic [CNT_W-1:0] stall_cnt;

   modport master (
      output d_op, d_rs, d_rt, e_op, e_rt, e_z, m_mem_acc, m_rdy,
      input  pcsrc, condep, pc_wr, ifid_wr, idex_wr, exmem_wr, ifid_flush, idex_flush,
      input  err, stall_cnt
   );

   modport slave (
      input  d_op, d_rs, d_rt, e_op, e_rt, e_z, m_mem_acc, m_rdy,
      output pcsrc, condep, pc_wr, ifid_wr, idex_wr, exmem_wr, ifid_flush, idex_flush,
      output err, stall_cnt
   );
endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Pure combinational hazard decode.
//  d_op_i/d_rs_i/d_rt_i : ID instruction
//  e_op_i/e_rt_i/e_z_i  : EX instruction and zero flag
//  br_taken_o           : EX holds a taken beq/bne
//  ldu_o                : load-use hazard between EX lw and ID consumer
module pipe_hazard_ctrl_hazard_detect
   import pipe_hazard_ctrl_pkg::*;
(
   input  logic [5:0] d_op_i,
   input  logic [4:0] d_rs_i,
   input  logic [4:0] d_rt_i,
   input  logic [5:0] e_op_i,
   input  logic [4:0] e_rt_i,
   input  logic       e_z_i,
   output logic       br_taken_o,
   output logic       ldu_o
);

   logic d_reads_rt;

   // Only these formats actually read rt as a source; lw/j/immediates do not
   assign d_reads_rt = (d_op_i == OpRtype) || (d_op_i == OpBeq) ||
                       (d_op_i == OpBne)   || (d_op_i == OpSw);

   assign br_taken_o = ((e_op_i == OpBeq) &&  e_z_i) ||
                       ((e_op_i == OpBne) && !e_z_i);

   // r0 is hard-wired, so a load to r0 never creates a dependency
   assign ldu_o = (e_op_i == OpLw) && (e_rt_i != 5'd0) &&
                  ((e_rt_i == d_rs_i) || ((e_rt_i == d_rt_i) && d_reads_rt));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard/sequencing controller of the 5-stage pipeline.
// Chooses the next-PC source, drives per-stage write enables and flushes, inserts
// load-use bubbles, freezes the pipeline while data memory is busy (with a timeout
// into a sticky error state) and counts stalled cycles.
//  clk : clock, rising edge
//  rst : asynchronous active-high reset
//  bus : pipe_hazard_ctrl_if slave modport (stage info in, control out)
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT = 64,
   parameter int unsigned CNT_W   = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   pipe_hazard_ctrl_if.slave     bus
);

   localparam int unsigned      WaitW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CntMax   = '1;

   state_e           state_q, state_d;
   logic [WaitW-1:0] wait_q, wait_d;
   logic [CNT_W-1:0] stall_q, stall_d;

   logic   freeze;
   logic   br_taken;
   logic   ldu;
   pcsrc_e pcsrc;
   logic   condep;
   logic   pc_wr, ifid_wr, idex_wr, exmem_wr;
   logic   ifid_flush, idex_flush;

   assign freeze = bus.m_mem_acc && !bus.m_rdy;

   pipe_hazard_ctrl_hazard_detect u_hazard_detect (
      .d_op_i     (bus.d_op),
      .d_rs_i     (bus.d_rs),
      .d_rt_i     (bus.d_rt),
      .e_op_i     (bus.e_op),
      .e_rt_i     (bus.e_rt),
      .e_z_i      (bus.e_z),
      .br_taken_o (br_taken),
      .ldu_o      (ldu)
   );

   // Output priority: freeze > taken branch > load-use > jump > sequential
   always_comb begin
      pcsrc      = PcsSeq;
      condep     = 1'b1;
      pc_wr      = 1'b0;
      ifid_wr    = 1'b0;
      idex_wr    = 1'b0;
      exmem_wr   = 1'b0;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      if (rst) begin
         // Pipeline registers fill with NOPs while reset is held
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (state_q != StErr) begin
         if (freeze) begin
            // Everything holds; branch/ldu in EX are re-evaluated after release
         end else if (br_taken) begin
            pcsrc      = PcsBr;
            condep     = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            {pc_wr, ifid_wr, idex_wr, exmem_wr} = 4'b1111;
         end else if (ldu) begin
            idex_flush = 1'b1;
            idex_wr    = 1'b1;
            exmem_wr   = 1'b1;
         end else if (bus.d_op == OpJ) begin
            pcsrc      = PcsJmp;
            ifid_flush = 1'b1;
            {pc_wr, ifid_wr, idex_wr, exmem_wr} = 4'b1111;
         end else begin
            {pc_wr, ifid_wr, idex_wr, exmem_wr} = 4'b1111;
         end
      end
   end

   // Next-state for the memory-wait FSM
   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      case (state_q)
         StRun: begin
            if (freeze) begin
               state_d = StMwait;
               wait_d  = WaitW'(1);
            end
         end
         StMwait: begin
            if (!freeze) begin
               state_d = StRun;
               wait_d  = '0;
            end else if (wait_q == WaitLast) begin
               state_d = StErr;
            end else begin
               wait_d = wait_q + WaitW'(1);
            end
         end
         default: begin
            state_d = StErr;
         end
      endcase
   end

   // Stalled cycles before the error state count; the error state itself does not
   always_comb begin
      stall_d = stall_q;
      if (!pc_wr && (state_q != StErr) && (stall_q != CntMax)) begin
         stall_d = stall_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StRun;
         wait_q  <= '0;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         stall_q <= stall_d;
      end
   end

   assign bus.pcsrc      = pcsrc;
   assign bus.condep     = condep;
   assign bus.pc_wr      = pc_wr;
   assign bus.ifid_wr    = ifid_wr;
   assign bus.idex_wr    = idex_wr;
   assign bus.exmem_wr   = exmem_wr;
   assign bus.ifid_flush = ifid_flush;
   assign bus.idex_flush = idex_flush;
   assign bus.err        = (state_q == StErr);
   assign bus.stall_cnt  = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (TIMEOUT=4, CNT_W=3).
module tb_pipe_hazard_ctrl;
   import pipe_hazard_ctrl_pkg::*;

   localparam int unsigned TOut = 4;
   localparam int unsigned CntW = 3;

   // Packed {pcsrc, condep, pc_wr, ifid_wr, idex_wr, exmem_wr, ifid_flush, idex_flush}
   localparam logic [8:0] OutRst  = 9'b00_1_0000_11;
   localparam logic [8:0] OutRun  = 9'b00_1_1111_00;
   localparam logic [8:0] OutHold = 9'b00_1_0000_00;
   localparam logic [8:0] OutBr   = 9'b10_0_1111_11;
   localparam logic [8:0] OutJmp  = 9'b11_1_1111_10;
   localparam logic [8:0] OutLdu  = 9'b00_1_0011_01;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   pipe_hazard_ctrl_if #(.CNT_W(CntW)) bus ();

   pipe_hazard_ctrl #(
      .TIMEOUT (TOut),
      .CNT_W   (CntW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   logic [8:0] outs;
   assign outs = {bus.pcsrc, bus.condep, bus.pc_wr, bus.ifid_wr, bus.idex_wr, bus.exmem_wr,
                  bus.ifid_flush, bus.idex_flush};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic drive(input logic [5:0] dop, input logic [4:0] drs, input logic [4:0] drt,
                        input logic [5:0] eop, input logic [4:0] ert, input logic ez,
                        input logic macc, input logic mrdy);
      bus.d_op      = dop;
      bus.d_rs      = drs;
      bus.d_rt      = drt;
      bus.e_op      = eop;
      bus.e_rt      = ert;
      bus.e_z       = ez;
      bus.m_mem_acc = macc;
      bus.m_rdy     = mrdy;
   endtask

   task automatic idle();
      drive(OpRtype, 5'd0, 5'd0, OpRtype, 5'd0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic edge_after();
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle();
      repeat (2) @(posedge clk);
      #1;
      check("rst_outs", 32'(outs), 32'(OutRst));
      check("rst_err", 32'(bus.err), 32'd0);
      check("rst_cnt", 32'(bus.stall_cnt), 32'd0);

      // Reset asserted while waiting on memory
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rel_outs", 32'(outs), 32'(OutRun));
      @(negedge clk);
      drive(OpRtype, 5'd0, 5'd0, OpRtype, 5'd0, 1'b0, 1'b1, 1'b0);
      #1;
      check("frz_outs", 32'(outs), 32'(OutHold));
      edge_after();
      check("frz_state", 32'(dut.state_q), 32'(StMwait));
      #1;
      rst = 1'b1;
      #1;
      check("arst_state", 32'(dut.state_q), 32'(StRun));
      check("arst_cnt", 32'(bus.stall_cnt), 32'd0);
      check("arst_outs", 32'(outs), 32'(OutRst));
      idle();
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("arel_outs", 32'(outs), 32'(OutRun));
      edge_after();
      check("arel_state", 32'(dut.state_q), 32'(StRun));
      check("arel_err", 32'(bus.err), 32'd0);
      check("arel_cnt", 32'(bus.stall_cnt), 32'd0);

      // Branch resolution against jump in ID
      @(negedge clk);
      drive(OpJ, 5'd0, 5'd0, OpBeq, 5'd0, 1'b1, 1'b0, 1'b1);
      #1;
      check("beq_vs_j", 32'(outs), 32'(OutBr));
      @(negedge clk);
      drive(OpRtype, 5'd0, 5'd0, OpBne, 5'd0, 1'b0, 1'b0, 1'b1);
      #1;
      check("bne_taken", 32'(outs), 32'(OutBr));
      @(negedge clk);
      drive(OpJ, 5'd0, 5'd0, OpBeq, 5'd0, 1'b0, 1'b0, 1'b1);
      #1;
      check("beq_nt_j", 32'(outs), 32'(OutJmp));
      edge_after();
      check("br_cnt", 32'(bus.stall_cnt), 32'd0);

      // Load-use bubbles
      do_reset();
      drive(OpRtype, 5'd0, 5'd5, OpLw, 5'd5, 1'b0, 1'b0, 1'b1);
      #1;
      check("ldu_rt", 32'(outs), 32'(OutLdu));
      edge_after();
      check("ldu_cnt1", 32'(bus.stall_cnt), 32'd1);
      @(negedge clk);
      drive(OpRtype, 5'd0, 5'd0, OpLw, 5'd0, 1'b0, 1'b0, 1'b1);
      #1;
      check("ldu_r0", 32'(outs), 32'(OutRun));
      @(negedge clk);
      drive(OpJ, 5'd0, 5'd5, OpLw, 5'd5, 1'b0, 1'b0, 1'b1);
      #1;
      check("j_rt_nodep", 32'(outs), 32'(OutJmp));
      @(negedge clk);
      drive(OpJ, 5'd5, 5'd0, OpLw, 5'd5, 1'b0, 1'b0, 1'b1);
      #1;
      check("ldu_rs_vs_j", 32'(outs), 32'(OutLdu));
      @(negedge clk);
      drive(OpRtype, 5'd5, 5'd5, OpSw, 5'd5, 1'b0, 1'b0, 1'b1);
      #1;
      check("sw_in_ex", 32'(outs), 32'(OutRun));
      edge_after();
      check("ldu_cnt2", 32'(bus.stall_cnt), 32'd2);

      // Memory freeze for 3 cycles with a taken branch deferred in EX
      do_reset();
      drive(OpRtype, 5'd0, 5'd0, OpBeq, 5'd0, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         #1;
         check($sformatf("mw_outs%0d", i), 32'(outs), 32'(OutHold));
         edge_after();
         check($sformatf("mw_state%0d", i), 32'(dut.state_q), 32'(StMwait));
         @(negedge clk);
      end
      check("mw_cnt", 32'(bus.stall_cnt), 32'd3);
      bus.m_rdy = 1'b1;
      #1;
      check("mw_rel_br", 32'(outs), 32'(OutBr));
      edge_after();
      check("mw_run", 32'(dut.state_q), 32'(StRun));
      check("mw_cnt_hold", 32'(bus.stall_cnt), 32'd3);
      check("mw_err", 32'(bus.err), 32'd0);

      // Timeout into the error state
      do_reset();
      drive(OpRtype, 5'd0, 5'd0, OpBeq, 5'd0, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         edge_after();
         check($sformatf("to_err%0d", i), 32'(bus.err), 32'd0);
      end
      edge_after();
      check("to_state", 32'(dut.state_q), 32'(StErr));
      check("to_err", 32'(bus.err), 32'd1);
      check("to_outs", 32'(outs), 32'(OutHold));
      @(negedge clk);
      bus.m_rdy = 1'b1;
      #1;
      check("err_br_ign", 32'(outs), 32'(OutHold));
      edge_after();
      edge_after();
      check("err_sticky", 32'(bus.err), 32'd1);
      check("err_cnt", 32'(bus.stall_cnt), 32'd4);

      // Counter saturation with repeated load-use bubbles
      do_reset();
      drive(OpRtype, 5'd3, 5'd0, OpLw, 5'd3, 1'b0, 1'b0, 1'b1);
      repeat (7) edge_after();
      check("sat_cnt7", 32'(bus.stall_cnt), 32'd7);
      repeat (3) edge_after();
      check("sat_cnt10", 32'(bus.stall_cnt), 32'd7);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
